// File: rtl/snoop_bus_arbiter.sv
// Three-processor snooping bus arbiter: grant, broadcast, snoop collect, write-back or memory read.
// Define SNOOP_FIXED_PRIO_EN for fixed priority 1 > 2 > 3; the default build uses round-robin.
module snoop_bus_arbiter #(
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 4,
    parameter int MEM_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [5:0]          req_cmd,
    input  logic [3*TAG_W-1:0]  req_tag,
    output logic [2:0]          gnt,
    output logic                bus_valid,
    output logic [1:0]          bus_cmd,
    output logic [TAG_W-1:0]    bus_tag,
    output logic [1:0]          bus_src,
    input  logic [2:0]          snp_done,
    input  logic [2:0]          snp_wb,
    input  logic [3*DATA_W-1:0] snp_data,
    output logic                mem_we,
    output logic                mem_re,
    output logic [TAG_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                busy
);

    localparam int CW = 4;
    localparam logic [1:0] CMD_INV = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SNOOP,
        WB,
        MEM,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [1:0]        src_q;
    logic [1:0]        cmd_q;
    logic [TAG_W-1:0]  tag_q;
    logic [2:0]        gnt_q;
    logic [2:0]        done_q;
    logic [2:0]        wb_q;
    logic [DATA_W-1:0] data_q [3];
    logic [DATA_W-1:0] rdata_q;
    logic [CW-1:0]     cnt_q;

    logic [2:0]        elig;
    logic [1:0]        cmd_a [3];
    logic [TAG_W-1:0]  tag_a [3];
    logic              win_any;
    logic [1:0]        win_idx;
    logic [2:0]        srcmask;
    logic [2:0]        cap;
    logic [2:0]        done_now;
    logic [2:0]        wb_now;
    logic [DATA_W-1:0] wb_data;
    logic              act;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cmd_a[i] = req_cmd[2*i +: 2];
            tag_a[i] = req_tag[TAG_W*i +: TAG_W];
            elig[i]  = req[i] && (cmd_a[i] != 2'd0);
        end
    end

`ifdef SNOOP_FIXED_PRIO_EN
    always_comb begin
        win_any = |elig;
        win_idx = 2'd0;
        priority case (1'b1)
            elig[0]: win_idx = 2'd0;
            elig[1]: win_idx = 2'd1;
            elig[2]: win_idx = 2'd2;
            default: win_idx = 2'd0;
        endcase
    end
`else
    logic [1:0] last_q;
    logic [1:0] o0, o1, o2;

    // Search starts just after the last winner; last_q = 2 gives processor 1 first pick.
    always_comb begin
        win_any = |elig;
        win_idx = 2'd0;
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
        unique case (last_q)
            2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (elig[o0])      win_idx = o0;
        else if (elig[o1]) win_idx = o1;
        else if (elig[o2]) win_idx = o2;
    end

    always_ff @(posedge clock) begin
        if (reset)
            last_q <= 2'd2;
        else if (state == RESP)
            last_q <= src_q;
    end
`endif

    // Only the first done from each non-source cache counts; its data is taken with it.
    always_comb begin
        srcmask  = 3'b001 << src_q;
        cap      = (state == SNOOP) ? (snp_done & ~srcmask & ~done_q) : 3'b000;
        done_now = done_q | cap;
        wb_now   = wb_q | (cap & snp_wb);
    end

    always_comb begin
        wb_data = data_q[2];
        priority case (1'b1)
            wb_q[0]: wb_data = data_q[0];
            wb_q[1]: wb_data = data_q[1];
            default: wb_data = data_q[2];
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (win_any) state_nx = ADDR;
            ADDR:  state_nx = SNOOP;
            SNOOP: begin
                if (&(done_now | srcmask)) begin
                    if (|wb_now)
                        state_nx = WB;
                    else if (cmd_q != CMD_INV)
                        state_nx = MEM;
                    else
                        state_nx = RESP;
                end
            end
            WB:    state_nx = RESP;
            MEM:   if (cnt_q == CW'(MEM_LAT)) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            src_q   <= 2'd0;
            cmd_q   <= 2'd0;
            tag_q   <= '0;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            wb_q    <= 3'b000;
            rdata_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 3; i++)
                data_q[i] <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        src_q   <= win_idx;
                        cmd_q   <= cmd_a[win_idx];
                        tag_q   <= tag_a[win_idx];
                        gnt_q   <= 3'b001 << win_idx;
                        done_q  <= 3'b000;
                        wb_q    <= 3'b000;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        for (int i = 0; i < 3; i++)
                            data_q[i] <= '0;
                    end
                end
                SNOOP: begin
                    done_q <= done_now;
                    wb_q   <= wb_now;
                    for (int i = 0; i < 3; i++)
                        if (cap[i])
                            data_q[i] <= snp_data[DATA_W*i +: DATA_W];
                end
                WB: rdata_q <= wb_data;
                MEM: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(MEM_LAT))
                        rdata_q <= mem_rdata;
                end
                RESP: gnt_q <= 3'b000;
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is held so a mid-transaction reset cuts cleanly.
    always_comb begin
        act        = !reset;
        gnt        = act ? gnt_q : 3'b000;
        bus_valid  = act && (state == ADDR);
        bus_cmd    = bus_valid ? cmd_q : 2'd0;
        bus_tag    = bus_valid ? tag_q : '0;
        bus_src    = bus_valid ? (src_q + 2'd1) : 2'd0;
        mem_we     = act && (state == WB);
        mem_re     = act && (state == MEM) && (cnt_q == '0);
        mem_addr   = (mem_we || (act && state == MEM)) ? tag_q : '0;
        mem_wdata  = mem_we ? wb_data : '0;
        resp_valid = act && (state == RESP);
        resp_data  = act ? rdata_q : '0;
        busy       = act && (state != IDLE);
    end

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 Parameter TAG_W, default 3: tag/address width.
REQ-002 Parameter DATA_W, default 4: data width.
REQ-003 Parameter MEM_LAT, default 2: memory read latency in cycles (1-15).
REQ-004 clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  per-processor bus request; bit0 = processor 1, bit2 = processor 3.
REQ-007 req_cmd  input  6  2 bits per processor [2p-1:2p-2]: 1 read miss, 2 write miss, 3 invalidate, 0 illegal.
REQ-008 req_tag  input  3*TAG_W  per-processor block tag, packed like req_cmd.
REQ-009 gnt  output  3  one-hot grant, held for the whole transaction.
REQ-010 bus_valid, bus_cmd, bus_tag, bus_src  output  1, 2, TAG_W, 2  broadcast phase; bus_src = processor number 1..3.
REQ-011 snp_done, snp_wb  input  3, 3  per-cache snoop complete / write-back-required flags.
REQ-012 snp_data  input  3*DATA_W  per-cache write-back data, valid with snp_done and snp_wb.
REQ-013 mem_we, mem_re, mem_addr, mem_wdata  output  1, 1, TAG_W, DATA_W  memory port.
REQ-014 mem_rdata  input  DATA_W  memory read data.
REQ-015 resp_valid, resp_data, busy  output  1, DATA_W, 1  completion pulse, returned block, transaction active.

Function
REQ-016 FSM states SHALL be IDLE, ADDR, SNOOP, WB, MEM, RESP; busy = (state != IDLE).
REQ-017 IDLE: a processor is eligible when req=1 and cmd!=0; with any eligible processor, arbitrate, latch winner cmd/tag, assert gnt, go to ADDR next cycle.
REQ-018 Round-robin: search order starts at processor after last winner, wrapping 3->1; pointer updates only in RESP.
REQ-019 ADDR: bus_valid=1 for exactly one cycle with latched cmd/tag/src; next state SNOOP.
REQ-020 SNOOP: collect snp_done and snp_wb into sticky bits for the two non-source caches; source cache bits ignored; bits may arrive in any cycle order, including same cycle.
REQ-021 SNOOP exit when both non-source done bits set: any wb -> WB; else cmd 1 or 2 -> MEM; else (invalidate) -> RESP.
REQ-022 If two caches flag wb, lowest processor number supplies data.
REQ-023 Snoop data SHALL be latched in the cycle its snp_done is sampled.
REQ-024 WB: mem_we=1 one cycle, mem_addr=tag, mem_wdata=latched data; resp_data=that data; next RESP (no memory read).
REQ-025 MEM: mem_re=1 in first cycle only, mem_addr=tag; mem_rdata sampled after exactly MEM_LAT cycles into resp_data; next RESP.
REQ-026 RESP: resp_valid=1 one cycle; gnt cleared the following cycle; next IDLE; invalidate returns resp_data=0.
REQ-027 Read miss without wb completes with resp_valid exactly 3+S+MEM_LAT cycles after the IDLE cycle that accepted it, where S = SNOOP cycles (S>=1).
REQ-028 Deasserting req mid-transaction SHALL NOT abort; transaction completes. Request changes outside IDLE are ignored.
REQ-029 New arbitration earliest in the IDLE cycle following RESP; no back-to-back overlap.

Reset
REQ-030 reset SHALL force IDLE, clear sticky bits and latches, set round-robin pointer so processor 1 has priority.
REQ-031 During and after reset all outputs SHALL be 0, including mid-transaction reset; no partial memory write is issued.

Configuration
REQ-032 Macro SNOOP_FIXED_PRIO_EN: defined -> fixed priority processor 1 > 2 > 3, pointer unused; undefined -> round-robin per REQ-018.

Verification
REQ-033 Reset, req=3'b111 all read miss, snoops clean, MEM_LAT=2 -> grant order 1,2,3,1 (round-robin); fixed order 1,1,1 with macro.
REQ-034 P2 read miss tag 5, P1 done+wb data 4'hA, P3 done clean -> mem_we=1 addr 5 wdata A, resp_data=A, no mem_re.
REQ-035 P3 read miss tag 2, mem holds 4'h6, P1/P2 done same cycle -> mem_re one cycle, resp_data=6, resp_valid at 3+1+2 cycles.
REQ-036 P1 invalidate tag 1, P3 done two cycles before P2 -> stays SNOOP until P2 done, resp_data=0, no memory access.
REQ-037 Reset asserted in MEM state -> next cycle all outputs 0, busy=0; subsequent P3-only request granted normally.
